// File: rtl/bp_fe_fetch_queue.sv
// -----------------------------------------------------------------------------
// bp_fe_fetch_queue
//
// Decoupling FIFO between the FE fetch pipeline (pc_gen/mem pair) and the BE
// fe_queue port. It replaces the fixed single-entry FE->BE handoff with a queue
// of configurable depth and payload width. It also reports occupancy and can be
// flushed by the BE.
//
// Parameters
//   els_p        queue depth in entries (>= 2, need not be a power of two)
//   width_p      payload width in bits; the FE top sets this to fe_queue_width_lp
//   ptr_width_lp read/write pointer width (safe clog2 of els_p)
//   cnt_width_lp occupancy width (safe clog2 of els_p+1)
//
// Ports
//   clk_i             clock
//   reset_i           synchronous, active-high reset (has priority over flush_i)
//   enq_i / enq_v_i   packet from the fetch pipeline and its valid
//   enq_ready_o       queue can accept; enqueue fires on enq_v_i & enq_ready_o
//   fe_queue_o        head packet to the BE
//   fe_queue_v_o      head valid
//   fe_queue_ready_i  BE accepts; dequeue fires on fe_queue_v_o & fe_queue_ready_i
//   flush_i           BE redirect: discard every entry this cycle
//   count_o           current occupancy
//
// Configuration macro
//   BP_FE_FETCH_QUEUE_BYPASS_EN  when defined, an empty, unflushed queue passes
//   enq_i straight to fe_queue_o in the same cycle. If the BE takes the packet
//   in that cycle, the packet is never written to storage.
// -----------------------------------------------------------------------------
module bp_fe_fetch_queue #(
  parameter  int els_p        = 4,
  parameter  int width_p      = 64,
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp = (els_p > 0) ? $clog2(els_p + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      enq_i,
  input  logic                    enq_v_i,
  output logic                    enq_ready_o,
  output logic [width_p-1:0]      fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_ready_i,
  input  logic                    flush_i,
  output logic [cnt_width_lp-1:0] count_o
);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r;
  logic [ptr_width_lp-1:0] wptr_r;
  logic [cnt_width_lp-1:0] count_r;

  logic empty_s;
  logic full_s;
  logic enq_fire_s;
  logic deq_fire_s;
  logic write_s;  // enqueue that actually lands in storage
  logic pop_s;    // dequeue that actually removes a stored entry
`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  logic bypass_s;
`endif

  // The wrap is explicit so that non-power-of-two depths still cycle through every entry.
  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] ptr);
    next_ptr = (ptr == last_ptr_lp) ? ptr_width_lp'(0) : ptr + ptr_width_lp'(1);
  endfunction

  // Handshake and head selection, derived from registered occupancy and flush_i.
  always_comb begin
    empty_s     = (count_r == cnt_width_lp'(0));
    full_s      = (count_r == full_cnt_lp);
    // A full queue refuses enq even if a dequeue fires in the same cycle.
    // Doing so keeps enq_ready_o off the fe_queue_ready_i path.
    enq_ready_o = ~full_s & ~flush_i;
    enq_fire_s  = enq_v_i & enq_ready_o;
`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
    bypass_s = empty_s & ~flush_i;
    if (bypass_s) begin
      fe_queue_v_o = enq_v_i;
      fe_queue_o   = enq_i;
    end else begin
      fe_queue_v_o = ~empty_s & ~flush_i;
      fe_queue_o   = mem_r[rptr_r];
    end
    deq_fire_s = fe_queue_v_o & fe_queue_ready_i;
    // A bypassed packet consumed in the same cycle never touches storage.
    write_s    = enq_fire_s & ~(bypass_s & fe_queue_ready_i);
    pop_s      = deq_fire_s & ~empty_s;
`else
    fe_queue_v_o = ~empty_s & ~flush_i;
    fe_queue_o   = mem_r[rptr_r];
    deq_fire_s   = fe_queue_v_o & fe_queue_ready_i;
    write_s      = enq_fire_s;
    pop_s        = deq_fire_s;
`endif
  end

  // Pointer and occupancy state; reset outranks flush, and flush outranks any transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= ptr_width_lp'(0);
      wptr_r  <= ptr_width_lp'(0);
      count_r <= cnt_width_lp'(0);
    end else if (flush_i) begin
      rptr_r  <= ptr_width_lp'(0);
      wptr_r  <= ptr_width_lp'(0);
      count_r <= cnt_width_lp'(0);
    end else begin
      if (write_s) begin
        wptr_r <= next_ptr(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= next_ptr(rptr_r);
      end
      count_r <= count_r + cnt_width_lp'(write_s) - cnt_width_lp'(pop_s);
    end
  end

  // Payload storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (write_s) begin
      mem_r[wptr_r] <= enq_i;
    end
  end

  assign count_o = count_r;

  bp_fe_fetch_queue_checker #(
    .els_p       (els_p),
    .cnt_width_lp(cnt_width_lp)
  ) checker_inst (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .write_i(write_s),
    .pop_i  (pop_s),
    .count_i(count_r)
  );

endmodule

// -----------------------------------------------------------------------------
// bp_fe_fetch_queue_checker
//
// Property checks for the fetch queue: no storage write while full and no
// storage pop while empty.
//
// Ports
//   clk_i, reset_i, flush_i  queue clock, reset and flush
//   write_i, pop_i           storage write / pop strobes
//   count_i                  registered occupancy
// -----------------------------------------------------------------------------
module bp_fe_fetch_queue_checker #(
  parameter int els_p        = 4,
  parameter int cnt_width_lp = 3
) (
  input logic                    clk_i,
  input logic                    reset_i,
  input logic                    flush_i,
  input logic                    write_i,
  input logic                    pop_i,
  input logic [cnt_width_lp-1:0] count_i
);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  no_enq_when_full_a: assert property (@(posedge clk_i) disable iff (reset_i || flush_i)
    !(write_i && (count_i == full_cnt_lp)));

  no_deq_when_empty_a: assert property (@(posedge clk_i) disable iff (reset_i || flush_i)
    !(pop_i && (count_i == cnt_width_lp'(0)) && !write_i));

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
module tb_bp_fe_fetch_queue;

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  localparam logic byp_c = 1'b1;
`else
  localparam logic byp_c = 1'b0;
`endif

  localparam int w_c = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-4 instance used by the vector table
  logic           rst, flush, enq_v, rdy;
  logic [w_c-1:0] enq;
  logic           enq_ready, v;
  logic [w_c-1:0] data;
  logic [2:0]     cnt;

  // Depth-3 instance used by the streaming sequence
  logic           s_rst, s_flush, s_enq_v, s_rdy;
  logic [w_c-1:0] s_enq;
  logic           s_enq_ready, s_v;
  logic [w_c-1:0] s_data;
  logic [1:0]     s_cnt;

  bp_fe_fetch_queue #(.els_p(4), .width_p(w_c)) dut4 (
    .clk_i(clk), .reset_i(rst), .enq_i(enq), .enq_v_i(enq_v), .enq_ready_o(enq_ready),
    .fe_queue_o(data), .fe_queue_v_o(v), .fe_queue_ready_i(rdy), .flush_i(flush),
    .count_o(cnt)
  );

  bp_fe_fetch_queue #(.els_p(3), .width_p(w_c)) dut3 (
    .clk_i(clk), .reset_i(s_rst), .enq_i(s_enq), .enq_v_i(s_enq_v), .enq_ready_o(s_enq_ready),
    .fe_queue_o(s_data), .fe_queue_v_o(s_v), .fe_queue_ready_i(s_rdy), .flush_i(s_flush),
    .count_o(s_cnt)
  );

  typedef struct {
    logic           rst;
    logic           flush;
    logic           enq_v;
    logic [w_c-1:0] enq;
    logic           rdy;
    logic           chk;
    logic           e_ready;
    logic           e_v;
    logic [w_c-1:0] e_data;
    logic [2:0]     e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic f, input logic ev, input logic [w_c-1:0] e,
                     input logic rd, input logic c, input logic x_ready, input logic x_v,
                     input logic [w_c-1:0] x_data, input logic [2:0] x_cnt);
    vec_t t;
    t.rst = r; t.flush = f; t.enq_v = ev; t.enq = e; t.rdy = rd; t.chk = c;
    t.e_ready = x_ready; t.e_v = x_v; t.e_data = x_data; t.e_cnt = x_cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_v = 1'b0; enq = '0; rdy = 1'b0;
    s_rst = 1'b1; s_flush = 1'b0; s_enq_v = 1'b0; s_enq = '0; s_rdy = 1'b0;

    //   rst   flush enq_v enq       rdy   chk   ready v      data      cnt
    add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0,  16'h0000, 3'd0); // reset cycle
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0,  16'h0000, 3'd0); // reset state
    add(1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0, 1'b1, 1'b1, byp_c, 16'h00A1, 3'd0); // enq A
    add(1'b0, 1'b0, 1'b1, 16'h00B2, 1'b0, 1'b1, 1'b1, 1'b1,  16'h00A1, 3'd1); // enq B
    add(1'b0, 1'b0, 1'b1, 16'h00C3, 1'b0, 1'b1, 1'b1, 1'b1,  16'h00A1, 3'd2); // enq C
    add(1'b0, 1'b0, 1'b1, 16'h00D4, 1'b0, 1'b1, 1'b1, 1'b1,  16'h00A1, 3'd3); // enq D
    add(1'b0, 1'b0, 1'b1, 16'h00E5, 1'b0, 1'b1, 1'b0, 1'b1,  16'h00A1, 3'd4); // full, stalled
    add(1'b0, 1'b0, 1'b1, 16'h00E5, 1'b1, 1'b1, 1'b0, 1'b1,  16'h00A1, 3'd4); // full: deq A, enq refused
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1,  16'h00B2, 3'd3); // B at head
    add(1'b0, 1'b1, 1'b1, 16'h00F6, 1'b0, 1'b1, 1'b0, 1'b0,  16'h0000, 3'd3); // flush + enq F
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0,  16'h0000, 3'd0); // empty after flush
    add(1'b0, 1'b0, 1'b1, 16'h0017, 1'b0, 1'b1, 1'b1, byp_c, 16'h0017, 3'd0); // enq G
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1,  16'h0017, 3'd1); // G at head
    add(1'b0, 1'b0, 1'b1, 16'h0028, 1'b0, 1'b1, 1'b1, 1'b1,  16'h0017, 3'd1); // enq H
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1,  16'h0017, 3'd2); // count 2
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1,  16'h0017, 3'd2); // deq G (rptr 0->1)
    add(1'b0, 1'b0, 1'b1, 16'h0039, 1'b0, 1'b1, 1'b1, 1'b1,  16'h0028, 3'd1); // H at head, enq I
    add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,  16'h0000, 3'd2); // reset + flush
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0,  16'h0000, 3'd0); // reset values
    add(1'b0, 1'b0, 1'b1, 16'h004A, 1'b1, 1'b1, 1'b1, byp_c, 16'h004A, 3'd0); // empty, enq J + rdy
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, ~byp_c,16'h004A, 3'({2'b00, ~byp_c})); // J a cycle later without bypass
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0,  16'h0000, 3'd0); // drained

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; enq_v = vecs[i].enq_v;
      enq = vecs[i].enq; rdy = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d enq_ready", i), 32'(enq_ready), 32'(vecs[i].e_ready));
        check($sformatf("v%0d valid", i), 32'(v), 32'(vecs[i].e_v));
        check($sformatf("v%0d count", i), 32'(cnt), 32'(vecs[i].e_cnt));
        if (vecs[i].e_v) begin
          check($sformatf("v%0d data", i), 32'(data), 32'(vecs[i].e_data));
        end
      end
    end

    // Stream 10 packets through the depth-3 queue with both sides always ready.
    @(negedge clk);
    s_rst = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      s_enq_v = (k < 10);
      s_enq   = 16'h0100 + 16'(k);
      s_rdy   = 1'b1;
      #1;
      if (byp_c) begin
        check($sformatf("s%0d count", k), 32'(s_cnt), 32'd0);
        check($sformatf("s%0d valid", k), 32'(s_v), 32'(k < 10));
        if (k < 10) begin
          check($sformatf("s%0d data", k), 32'(s_data), 32'h0100 + 32'(k));
        end
      end else if (k == 0) begin
        check("s0 count", 32'(s_cnt), 32'd0);
        check("s0 valid", 32'(s_v), 32'd0);
      end else begin
        check($sformatf("s%0d count", k), 32'(s_cnt), 32'd1);
        check($sformatf("s%0d valid", k), 32'(s_v), 32'd1);
        check($sformatf("s%0d data", k), 32'(s_data), 32'h0100 + 32'(k - 1));
      end
    end
    @(negedge clk);
    s_enq_v = 1'b0;
    s_rdy   = 1'b0;
    #1;
    check("s_end count", 32'(s_cnt), 32'd0);
    check("s_end valid", 32'(s_v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
